// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and a single-port, word-indexed data memory.
// Define LSU_ALIGN_CHECK_EN to reject misaligned halfword/word requests at accept.
module dmem_lsu #(
    parameter int DEPTH       = 1024,
    parameter int MEM_RD_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rdata,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    localparam logic [2:0] LP_WAIT_LAST = 3'(MEM_RD_WAIT - 1);

    state_t      r_state;
    logic [2:0]  r_wait_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;

    logic [31:0] w_idx;
    logic        w_oob;
    logic        w_misalign;
    logic        w_reject;

    // A transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and ready is only high in IDLE (request) / driven by the consumer (response).
    assign w_idx = {2'b00, i_req_addr[31:2]};
    assign w_oob = (w_idx >= 32'(DEPTH));

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = ((i_req_size == 2'd1) && i_req_addr[0]) ||
                        ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject    = (i_req_size == 2'd3) || w_oob || w_misalign;
    assign o_dbg_state = r_state;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    res = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    res = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] res;
        res = old;
        case (size)
            2'd0: res[{lane, 3'b000} +: 8] = data[7:0];
            2'd1: begin
                if (lane[1]) res[31:16] = data[15:0];
                else         res[15:0]  = data[15:0];
            end
            default: res = data;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 3'd0;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_lane      <= 2'd0;
            r_wdata     <= 32'h0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'h0;
            o_rsp_err   <= 1'b0;
            o_mem_addr  <= 32'h0;
            o_mem_wdata <= 32'h0;
            o_mem_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we        <= i_req_we;
                        r_size      <= i_req_size;
                        r_unsigned  <= i_req_unsigned;
                        r_lane      <= i_req_addr[1:0];
                        r_wdata     <= i_req_wdata;
                        r_wait_cnt  <= 3'd0;
                        o_req_ready <= 1'b0;
                        if (w_reject) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_rdata <= 32'h0;
                            r_state     <= S_RSP;
                        end else begin
                            o_mem_addr <= w_idx;
                            if (i_req_we && (i_req_size == 2'd2)) begin
                                o_mem_wdata <= i_req_wdata;
                                o_mem_we    <= 1'b1;
                                r_state     <= S_WR;
                            end else begin
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (r_wait_cnt == LP_WAIT_LAST) begin
                        if (r_we) begin
                            // Read-modify-write: untouched lanes keep what memory returned.
                            o_mem_wdata <= store_merge(i_mem_rdata, r_wdata, r_size, r_lane);
                            o_mem_we    <= 1'b1;
                            r_state     <= S_WR;
                        end else begin
                            o_rsp_rdata <= load_extend(i_mem_rdata, r_size, r_lane, r_unsigned);
                            o_rsp_valid <= 1'b1;
                            r_state     <= S_RSP;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                S_WR: begin
                    o_mem_we    <= 1'b0;
                    o_rsp_valid <= 1'b1;
                    o_rsp_rdata <= 32'h0;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_rsp_err   <= 1'b0;
                        o_rsp_rdata <= 32'h0;
                        o_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: random and directed loads/stores against a word-array reference model,
// with response and memory-write scoreboards checked by an independent monitor.
module tb_dmem_lsu;
  localparam int DEPTH = 1024;
  localparam int WAIT  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'd0;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = 32'h0;
  logic [31:0] i_req_wdata = 32'h0;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we;
  logic [31:0] i_mem_rdata;
  logic [1:0]  o_dbg_state;

  dmem_lsu #(.DEPTH(DEPTH), .MEM_RD_WAIT(WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
    .i_mem_rdata(i_mem_rdata), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- attached memory and reference ----------------
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int act_writes = 0;
  int exp_writes = 0;

  assign i_mem_rdata = (o_mem_addr < 32'(DEPTH)) ? mem[o_mem_addr[9:0]] : 32'h0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    forever begin
      @(posedge clk);
      if (o_mem_we) begin
        mem[o_mem_addr[9:0]] <= o_mem_wdata;
        act_writes <= act_writes + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [64:0] exp_q[$];   // {err, rdata, cycle rsp_valid first seen}
  logic [95:0] wr_q[$];    // {cycle mem_we seen, word index, data}
  bit hold = 1'b0;
  bit seen_valid = 1'b0;
  bit prev_we = 1'b0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Called the cycle before the accept edge; cyc is then one less than after the accept.
  task automatic model_push(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
    int idx;
    int sh;
    bit err;
    logic [31:0] word, res, mask, nw;
    idx = int'(addr[31:2]);
    err = (size == 2'd3) || (addr[31:2] >= 30'(DEPTH));
`ifdef LSU_ALIGN_CHECK_EN
    err = err || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`endif
    if (err) begin
      exp_q.push_back({1'b1, 32'h0, 32'(cyc + 1)});
    end else if (!we) begin
      word = ref_mem[idx];
      if (size == 2'd0) begin
        sh = 8 * int'(addr[1:0]);
        res = (word >> sh) & 32'hFF;
        if (!uns && res[7]) res = res | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        sh = 16 * int'(addr[1]);
        res = (word >> sh) & 32'hFFFF;
        if (!uns && res[15]) res = res | 32'hFFFF_0000;
      end else begin
        res = word;
      end
      exp_q.push_back({1'b0, res, 32'(cyc + 1 + WAIT)});
    end else begin
      if (size == 2'd0) begin
        sh = 8 * int'(addr[1:0]);
        mask = 32'hFF << sh;
      end else if (size == 2'd1) begin
        sh = 16 * int'(addr[1]);
        mask = 32'hFFFF << sh;
      end else begin
        sh = 0;
        mask = 32'hFFFF_FFFF;
      end
      nw = (ref_mem[idx] & ~mask) | ((wdata << sh) & mask);
      ref_mem[idx] = nw;
      exp_writes++;
      if (size == 2'd2) begin
        wr_q.push_back({32'(cyc + 1), 32'(idx), nw});
        exp_q.push_back({1'b0, 32'h0, 32'(cyc + 2)});
      end else begin
        wr_q.push_back({32'(cyc + 1 + WAIT), 32'(idx), nw});
        exp_q.push_back({1'b0, 32'h0, 32'(cyc + 2 + WAIT)});
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    logic [95:0] w;
    if (!rst_n) begin
      seen_valid = 1'b0;
      prev_we = 1'b0;
    end else begin
      if (o_mem_we) begin
        check("we_single_pulse", {95'h0, prev_we}, 96'h0);
        if (wr_q.size() == 0) begin
          check("unexpected_write", {32'(cyc), o_mem_addr, o_mem_wdata}, 96'h0);
        end else begin
          w = wr_q.pop_front();
          check("write_cyc_addr_data", {32'(cyc), o_mem_addr, o_mem_wdata}, w);
        end
      end
      prev_we = o_mem_we;
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {63'h0, o_rsp_err, o_rsp_rdata}, 96'h0);
        end else begin
          e = exp_q[0];
          if (!seen_valid) begin
            check("rsp_latency", 96'(cyc), 96'(e[31:0]));
            seen_valid = 1'b1;
          end
          check("rsp_err_rdata", {63'h0, o_rsp_err, o_rsp_rdata}, {63'h0, e[64:32]});
          check("req_ready_busy", 96'(o_req_ready), 96'h0);
          if (i_rsp_ready) begin
            void'(exp_q.pop_front());
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- response back-pressure ----------------
  initial begin
    i_rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input bit expect_it);
    int budget;
    @(negedge clk);
    i_req_we = we;
    i_req_size = size;
    i_req_unsigned = uns;
    i_req_addr = addr;
    i_req_wdata = wdata;
    i_req_valid = 1'b1;
    budget = 0;
    while (!o_req_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!o_req_ready) begin
      check("req_accept_timeout", 96'(o_req_ready), 96'h1);
      i_req_valid = 1'b0;
      return;
    end
    if (expect_it) model_push(we, size, uns, addr, wdata);
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 96'(o_req_ready), 96'h1);
    check({tag, "_rsp_valid"}, 96'(o_rsp_valid), 96'h0);
    check({tag, "_rsp_err"},   96'(o_rsp_err),   96'h0);
    check({tag, "_rsp_rdata"}, 96'(o_rsp_rdata), 96'h0);
    check({tag, "_mem_we"},    96'(o_mem_we),    96'h0);
    check({tag, "_mem_addr"},  96'(o_mem_addr),  96'h0);
    check({tag, "_mem_wdata"}, 96'(o_mem_wdata), 96'h0);
    check({tag, "_state"},     96'(o_dbg_state), 96'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    int writes_before;
    int bad_words;
    logic [1:0] sz;
    logic [31:0] ad;
    #1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // word store / load round trip
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    // byte read-modify-write
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 1'b1);
    send(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AA, 1'b1);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    // lane extraction
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01, 1'b1);
    send(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b1);
    send(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1);
    send(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b1);
    send(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b1);
    send(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1);
    send(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1);
    send(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1);
    send(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_BEEF, 1'b1);
    send(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1);
    // rejected requests
    send(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1);
    send(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1234_5678, 1'b1);
    send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1);
    send(1'b1, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1);
    // misaligned word store and halfword load (rejected only with the alignment check)
    send(1'b1, 2'd2, 1'b0, 32'h11, 32'hCAFE_F00D, 1'b1);
    send(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b1);

    // long back-pressure with a second request waiting
    hold = 1'b1;
    fork
      begin
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
        send(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1);
      end
      begin
        repeat (9) @(negedge clk);
        hold = 1'b0;
      end
    join

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 15) == 0) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                        : 32'($urandom_range(0, 63));
      send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 1'b1);
    end

    // drain before the reset-abort case
    budget = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    check("drain_before_reset", 96'(exp_q.size() + wr_q.size()), 96'h0);

    // reset while a sub-word store is in its read phase
    writes_before = act_writes;
    send(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_0055, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    check("abort_no_write", 96'(act_writes), 96'(writes_before));
    rst_n = 1'b1;

    for (int n = 0; n < 30; n++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 63)), $urandom, 1'b1);
    end

    budget = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    check("final_drain", 96'(exp_q.size() + wr_q.size()), 96'h0);
    check("write_count", 96'(act_writes), 96'(exp_writes));
    bad_words = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad_words++;
    check("memory_contents", 96'(bad_words), 96'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
